down_counter: RTL and testbench
===============================

# down_counter

Synchronous, loadable down-counter with terminal-count pulse and optional auto-reload. It is the count-down companion to the ripple up-counter: it consumes a preset value instead of producing an incrementing one. Unlike the ripple design, every bit is clocked by `clk`, so all bits change on the same edge. Downstream logic uses it as a programmable timer or clock divider, driving a one-cycle `tc` pulse when the count reaches zero.

## Interface
Parameters:
- WIDTH, 4, number of count bits; legal range 2..16.

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-high reset.
- load  input  1  load `d` into count and period registers.
- en  input  1  count enable; decrement or reload only when high.
- reload_en  input  1  when high, an enabled cycle at zero reloads the period.
- d  input  WIDTH  preset value for `load`.
- count  output  WIDTH  current count value (registered).
- zero  output  1  combinational, high when count == 0.
- tc  output  1  registered terminal-count pulse, one cycle wide.

## Operation
- Internal state: count[WIDTH-1:0], period P[WIDTH-1:0], tc flop.
- Reset (rst=1, asynchronous, independent of clk): count=0, P=0, tc=0. zero=1 during and after reset. Reset asserted mid-count aborts immediately. No pending tc survives reset.
- Per rising edge with rst=0, evaluated in priority order:
  - load=1: count<=d, P<=d, tc<=0. Overrides en regardless of count value.
  - en=1, count!=0: count<=count-1; tc<=1 if count==1, else tc<=0.
  - en=1, count==0, reload_en=1: count<=P, tc<=0.
  - en=1, count==0, reload_en=0: count holds at 0 (saturates, never wraps to all ones), tc<=0.
  - en=0: count and P hold, tc<=0.
- Arithmetic: unsigned, modulo-free. Decrement is never applied at 0, so no underflow exists.
- Auto-reload period: with reload_en=1, en held high, and P>0, count cycles P, P-1, …, 1, 0, P, and so on. tc pulses once every P+1 enabled cycles.
- P=0 with reload_en=1: count stays at 0, and tc never asserts.
- load with d=0: count=0 and zero=1 next cycle. No tc is produced, because tc comes only from a 1->0 decrement.
- Changing reload_en mid-count takes effect only at the next zero cycle.

## Timing
- count and tc are registered: one-cycle latency from the qualifying edge.
- tc rises on the same edge that count becomes 0 via decrement. It is high for exactly one cycle unless the next edge again decrements 1->0, which is impossible, so tc is never high on consecutive cycles.
- zero is combinational from count, so zero and tc are both high in the cycle after the 1->0 edge.
- Gating en low while count==1 delays both the decrement and tc until en returns high.
- load and en both high on the same edge: load wins, and no decrement occurs that cycle.
- Async reset deassertion is taken as synchronous to clk by the surrounding design. The first active edge after deassertion obeys the normal rules.

## Test plan
- Reset: drive count to 5, assert rst between edges. Expect count=0, zero=1, tc=0 immediately, without a clock edge.
- One-shot: load d=3, then en=1 with reload_en=0. Expect count 3,2,1,0,0,0 on successive edges, tc=1 only in the cycle count first shows 0, and zero=1 from then on.
- Auto-reload: load d=2, then en=1 with reload_en=1 for 9 edges. Expect count 2,1,0,2,1,0,2,1,0 and tc high exactly 3 times, spaced 3 cycles apart.
- Enable gating: load d=2, run en=1 for 1 edge, then en=0 for 3 edges, then en=1. Expect count to hold at 1 for 3 cycles, then reach 0 with tc=1.
- Priority: at count=1, assert load=1, en=1, d=9 together. Expect count=9 and tc=0, with no terminal pulse generated.
- Boundaries (WIDTH=4): load d=15 with reload_en=1; expect 16 cycles between tc pulses. Load d=0 with reload_en=1; expect count fixed at 0, zero=1, and tc never asserting.

Source files
------------

// File: rtl/down_counter.sv
// rtl/down_counter.sv - loadable synchronous down-counter with terminal-count pulse and auto-reload
module down_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    input  logic             reload_en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] count,
    output logic             zero,
    output logic             tc
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] period;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count  <= '0;
            period <= '0;
            tc     <= 1'b0;
        end else if (load) begin
            count  <= d;
            period <= d;
            tc     <= 1'b0;
        end else if (en && !zero) begin
            // tc is only ever produced by the 1->0 decrement
            count <= count - ONE;
            tc    <= (count == ONE);
        end else if (en && reload_en) begin
            count <= period;
            tc    <= 1'b0;
        end else begin
            tc <= 1'b0;
        end
    end

    assign zero = (count == '0);

endmodule

// File: tb/tb_down_counter.sv
// tb/tb_down_counter.sv - randomized self-checking bench for down_counter against a behavioural model
module tb_down_counter;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         load;
    logic         en;
    logic         reload_en;
    logic [W-1:0] d;
    logic [W-1:0] count;
    logic         zero;
    logic         tc;

    int n_tests = 0;
    int n_fail  = 0;

    int m_count  = 0;
    int m_period = 0;
    int m_tc     = 0;

    down_counter #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .en        (en),
        .reload_en (reload_en),
        .d         (d),
        .count     (count),
        .zero      (zero),
        .tc        (tc)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".count"}, int'(count), m_count);
        check({tag, ".zero"},  int'(zero),  (m_count == 0) ? 1 : 0);
        check({tag, ".tc"},    int'(tc),    m_tc);
    endtask

    // Drive one cycle of inputs, advance the model by the same edge, then compare
    task automatic step(input string tag, input logic l, input logic e,
                        input logic r, input int dv);
        load = l; en = e; reload_en = r; d = W'(dv);
        @(posedge clk);
        if (l) begin
            m_count = dv; m_period = dv; m_tc = 0;
        end else if (e && m_count > 0) begin
            m_tc = (m_count == 1) ? 1 : 0;
            m_count = m_count - 1;
        end else if (e && r) begin
            m_count = m_period; m_tc = 0;
        end else begin
            m_tc = 0;
        end
        #1;
        check_outputs(tag);
    endtask

    // Asynchronous reset pulse placed between clock edges
    task automatic async_reset(input string tag);
        #2 rst = 1'b1;
        #1;
        m_count = 0; m_period = 0; m_tc = 0;
        check_outputs(tag);
        rst = 1'b0;
    endtask

    initial begin
        int tc_hits;
        int first_tc;
        int second_tc;

        rst = 1'b1; load = 1'b0; en = 1'b0; reload_en = 1'b0; d = '0;
        #7;
        check_outputs("reset");
        rst = 1'b0;

        // Reset mid-count and with a pending tc
        step("rst_ld", 1, 0, 0, 5);
        check("rst_ld5", int'(count), 5);
        async_reset("rst_mid");
        check("rst_mid_zero", int'(zero), 1);
        step("rst_ld1", 1, 0, 0, 1);
        step("rst_tc", 0, 1, 0, 0);
        check("rst_tc_hi", int'(tc), 1);
        async_reset("rst_tc_clear");
        check("rst_tc_lo", int'(tc), 0);

        // One-shot
        step("os_ld", 1, 0, 0, 3);
        for (int i = 0; i < 5; i++) step("oneshot", 0, 1, 0, 0);
        check("os_sat", int'(count), 0);

        // Auto-reload d=2: tc three times, three cycles apart
        step("ar_ld", 1, 0, 1, 2);
        tc_hits = 0; first_tc = -1; second_tc = -1;
        for (int i = 1; i <= 9; i++) begin
            step("autoreload", 0, 1, 1, 0);
            if (tc) begin
                tc_hits++;
                if (first_tc < 0) first_tc = i;
                else if (second_tc < 0) second_tc = i;
            end
        end
        check("ar_tc_hits", tc_hits, 3);
        check("ar_spacing", second_tc - first_tc, 3);

        // Enable gating at count==1
        step("eg_ld", 1, 0, 0, 2);
        step("eg_run", 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step("eg_hold", 0, 0, 0, 0);
            check("eg_hold1", int'(count), 1);
        end
        step("eg_fire", 0, 1, 0, 0);
        check("eg_tc", int'(tc), 1);

        // load beats en at count==1
        step("pr_ld", 1, 0, 0, 1);
        step("pr_both", 1, 1, 0, 9);
        check("pr_count", int'(count), 9);
        check("pr_tc", int'(tc), 0);

        // Full-scale period: 16 enabled cycles between tc pulses
        step("max_ld", 1, 0, 1, 15);
        first_tc = -1; second_tc = -1;
        for (int i = 1; i <= 40; i++) begin
            step("max_run", 0, 1, 1, 0);
            if (tc) begin
                if (first_tc < 0) first_tc = i;
                else if (second_tc < 0) second_tc = i;
            end
        end
        check("max_found", (second_tc > 0) ? 1 : 0, 1);
        check("max_spacing", second_tc - first_tc, 16);

        // Period zero with reload: stuck at zero, never tc
        step("p0_ld", 1, 0, 1, 0);
        tc_hits = 0;
        for (int i = 0; i < 20; i++) begin
            step("p0_run", 0, 1, 1, 0);
            if (tc) tc_hits++;
        end
        check("p0_no_tc", tc_hits, 0);
        check("p0_zero", int'(zero), 1);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            step("rand",
                 ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 9) < 7),
                 $urandom_range(0, 1),
                 int'($urandom_range(0, (1 << W) - 1)));
            if ($urandom_range(0, 99) == 0) async_reset("rand_rst");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
